// File: rtl/alu_pipe.sv
// alu_pipe: width-parametrised registered ALU with valid/ready handshakes on
// the issue and writeback sides. Most ops complete in one cycle. MUL uses an
// iterative shift-add multiplier that processes one multiplier bit per cycle.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  issue handshake; op, in1 and in2 are latched on transfer
//   op                   operation code (0..12 legal, 13..15 raise err)
//   in1, in2             operands A and B
//   out_valid/out_ready  writeback handshake; outputs are held while stalled
//   out                  result
//   flag_z/n/c/v         zero, negative, carry/borrow/shift-out, signed overflow
//   err                  illegal op code
//
// state | meaning
// IDLE  | no result pending, ready for a new op
// MUL   | multiplier iterating, issue blocked
// DONE  | result valid on out, waiting for out_ready
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_PASS = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [CW-1:0]      mul_cnt;
  logic [2*WIDTH-1:0] mul_sum;

  logic             accept;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;
  logic             alu_e;

  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign amt      = in2[SHW-1:0];
  assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (op)
      OP_ADD: begin
        {alu_c, alu_r} = {1'b0, in1} + {1'b0, in2};
        alu_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (alu_r[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        // top bit of the (WIDTH+1)-bit difference is the unsigned borrow
        {alu_c, alu_r} = {1'b0, in1} - {1'b0, in2};
        alu_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (alu_r[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  alu_r = in1 & in2;
      OP_OR:   alu_r = in1 | in2;
      OP_XOR:  alu_r = in1 ^ in2;
      OP_NOT:  alu_r = ~in1;
      // The extra guard bit catches the last bit shifted out. It stays 0 when amt is 0.
      OP_SHL:  {alu_c, alu_r} = {1'b0, in1} << amt;
      OP_SHR:  {alu_r, alu_c} = {in1, 1'b0} >> amt;
      OP_SRA:  {alu_r, alu_c} = $signed({in1, 1'b0}) >>> amt;
      OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_MUL:  alu_r = '0;
      OP_PASS: alu_r = in2;
      default: alu_e = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out        <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      err        <= 1'b0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else if (accept) begin
      // Accept happens only from IDLE or a retiring DONE. A stalled result is never overwritten.
      if (op == OP_MUL) begin
        state      <= S_MUL;
        out_valid  <= 1'b0;
        mul_acc    <= '0;
        mul_mcand  <= {{WIDTH{1'b0}}, in1};
        mul_mplier <= in2;
        mul_cnt    <= CW'(WIDTH);
      end else begin
        state     <= S_DONE;
        out_valid <= 1'b1;
        out       <= alu_r;
        flag_z    <= (alu_r == '0);
        flag_n    <= alu_r[WIDTH-1];
        flag_c    <= alu_c;
        flag_v    <= alu_v;
        err       <= alu_e;
      end
    end else begin
      case (state)
        S_MUL: begin
          if (mul_cnt != '0) begin
            mul_acc    <= mul_sum;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt - 1'b1;
          end else begin
            // All bits have been added. Publishing the result takes one extra cycle.
            state     <= S_DONE;
            out_valid <= 1'b1;
            out       <= mul_acc[WIDTH-1:0];
            flag_z    <= (mul_acc[WIDTH-1:0] == '0);
            flag_n    <= mul_acc[WIDTH-1];
            flag_c    <= |mul_acc[2*WIDTH-1:WIDTH];
            flag_v    <= 1'b0;
            err       <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
